// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for the icache/dcache pair: data has priority, a starvation
// counter forces an instruction grant, and a watchdog flags stalled or errored accesses.
module memory_arbiter #(
  parameter int ISTARVE_MAX = 4,
  parameter int RAM_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int SW = $clog2(ISTARVE_MAX + 1);
  localparam int TW = $clog2(RAM_TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(ISTARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(RAM_TIMEOUT - 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DATA, INSTR, ERR} state_t;

  state_t          state, next_state;
  logic [SW-1:0]   starve, starve_next;
  logic [TW-1:0]   tmo;
  logic            memerr_set;
  logic            d_req;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
      tmo    <= '0;
      memerr <= 1'b0;
    end else begin
      state  <= next_state;
      starve <= starve_next;
      // Idle/ERR park the counter at zero so every grant starts a fresh timeout window.
      tmo    <= (state == DATA || state == INSTR) ? tmo + 1'b1 : '0;
      if (memerr_set) memerr <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    starve_next = starve;
    memerr_set  = 1'b0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    unique case (state)
      IDLE: begin
        if (d_req && !(starve == STARVE_MAX && iREN)) begin
          next_state = DATA;
          if (!iREN)                    starve_next = '0;
          else if (starve != STARVE_MAX) starve_next = starve + 1'b1;
        end else if (iREN) begin
          next_state  = INSTR;
          starve_next = '0;
        end
      end

      DATA: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == RS_ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            next_state = IDLE;
          end else if (ramstate == RS_ERROR) begin
            next_state = ERR;
            memerr_set = 1'b1;
          end else if (tmo == TMO_LAST) begin
            next_state = IDLE;
            memerr_set = 1'b1;
          end
        end
      end

      INSTR: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RS_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end else if (ramstate == RS_ERROR) begin
            next_state = ERR;
            memerr_set = 1'b1;
          end else if (tmo == TMO_LAST) begin
            next_state = IDLE;
            memerr_set = 1'b1;
          end
        end
      end

      ERR: next_state = IDLE;

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a small RAM model driving ramstate/ramload.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int failures = 0;
  int busy = 0;
  int lat = 0;
  int ram_mode = 0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  memory_arbiter #(.ISTARVE_MAX(4), .RAM_TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rm(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  assign ramload = rm(ramaddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle: RAM model reacts to the strobes, then outputs are scored mid-cycle.
  task automatic step(output bit dc, output bit ic);
    @(negedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      lat++;
      if (ram_mode == 1) begin
        ramstate = 2'd3;
        ram_mode = 0;
      end else if (ram_mode == 2) begin
        ramstate = 2'd1;
      end else begin
        ramstate = (lat > busy) ? 2'd2 : 2'd1;
      end
    end else begin
      lat = 0;
      ramstate = 2'd0;
    end
    #1;
    check("both_wait_low", {31'b0, !dwait && !iwait}, 32'd0);
    check("both_strobes", {31'b0, ramREN && ramWEN}, 32'd0);
    dc = !dwait;
    ic = !iwait;
    if (dc) begin
      if (dq.size() == 0) check("d_unexpected", 32'd1, 32'd0);
      else check("dload", dload, dq.pop_front());
    end
    if (ic) begin
      if (iq.size() == 0) check("i_unexpected", 32'd1, 32'd0);
      else check("iload", iload, iq.pop_front());
    end
  endtask

  task automatic wait_done(input string tag, input bit want_d, input int maxc);
    bit dc, ic, got;
    got = 0;
    for (int k = 0; k < maxc && !got; k++) begin
      step(dc, ic);
      if (want_d ? dc : ic) got = 1;
    end
    check(tag, {31'b0, got}, 32'd1);
    if (want_d) begin dREN = 0; dWEN = 0; end
    else iREN = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    ram_mode = 0;
    repeat (2) @(negedge CLK);
    #2;
    nRST = 1;
    dq.delete();
    iq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit dc, ic;
    int n, icnt, ren_cnt, dlow;
    logic [9:0] seq;

    iaddr = 0; daddr = 0; dstore = 0; ramstate = 2'd0;
    do_reset();
    nRST = 0;
    #1;
    check("rst_iwait", {31'b0, iwait}, 32'd1);
    check("rst_dwait", {31'b0, dwait}, 32'd1);
    check("rst_ramREN", {31'b0, ramREN}, 32'd0);
    check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_loads", iload | dload, 32'd0);
    check("rst_memerr", {31'b0, memerr}, 32'd0);
    nRST = 1;

    // Single read with three BUSY cycles
    busy = 3;
    daddr = 32'h100; dREN = 1;
    dq.push_back(32'hDEADBEEF);
    for (int k = 1; k <= 5; k++) begin
      step(dc, ic);
      check($sformatf("sr_ramREN_c%0d", k), {31'b0, ramREN}, {31'b0, k <= 4});
      check($sformatf("sr_dwait_c%0d", k), {31'b0, dwait}, {31'b0, k != 4});
      if (k == 1) check("sr_ramaddr", ramaddr, 32'h100);
      if (dc) dREN = 0;
    end

    // Write priority over read and fetch
    busy = 1;
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
    iREN = 1; iaddr = 32'h300;
    dq.push_back(rm(32'h200));
    iq.push_back(rm(32'h300));
    step(dc, ic);
    check("wr_ramWEN", {31'b0, ramWEN}, 32'd1);
    check("wr_ramREN", {31'b0, ramREN}, 32'd0);
    check("wr_ramstore", ramstore, 32'h12345678);
    check("wr_ramaddr", ramaddr, 32'h200);
    check("wr_iwait", {31'b0, iwait}, 32'd1);
    wait_done("wr_done", 1, 10);
    wait_done("wr_ifetch", 0, 10);

    // Starvation: both requesters held, minimum latency
    busy = 0;
    dREN = 1; iREN = 1; daddr = 32'h1000; iaddr = 32'h2000;
    dq.push_back(rm(daddr));
    iq.push_back(rm(iaddr));
    n = 0; icnt = 0; seq = '0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      step(dc, ic);
      if (dc) begin
        seq = {seq[8:0], 1'b1}; n++;
        daddr = daddr + 4;
        dq.push_back(rm(daddr));
      end
      if (ic) begin
        seq = {seq[8:0], 1'b0}; n++; icnt++;
        iq.push_back(rm(iaddr));
      end
    end
    dREN = 0; iREN = 0;
    dq.delete(); iq.delete();
    check("starve_count", n, 10);
    check("starve_seq", {22'b0, seq}, {22'b0, 10'b1111011110});
    check("starve_ifetches", icnt, 2);
    step(dc, ic);

    // RAM ERROR then retry
    ram_mode = 1;
    dREN = 1; daddr = 32'h400;
    dq.push_back(rm(32'h400));
    step(dc, ic);
    check("err_memerr_pre", {31'b0, memerr}, 32'd0);
    step(dc, ic);
    check("err_memerr", {31'b0, memerr}, 32'd1);
    check("err_ramREN", {31'b0, ramREN}, 32'd0);
    check("err_dwait", {31'b0, dwait}, 32'd1);
    step(dc, ic);
    check("err_idle_ramREN", {31'b0, ramREN}, 32'd0);
    wait_done("err_retry", 1, 5);

    // Timeout with RAM stuck BUSY
    do_reset();
    ram_mode = 2;
    dREN = 1; daddr = 32'h500;
    ren_cnt = 0; dlow = 0;
    for (int k = 1; k <= 65; k++) begin
      step(dc, ic);
      if (ramREN) ren_cnt++;
      if (dc) dlow++;
      if (k == 64) check("tmo_memerr_pre", {31'b0, memerr}, 32'd0);
      if (k == 65) begin
        check("tmo_memerr", {31'b0, memerr}, 32'd1);
        check("tmo_ramREN_off", {31'b0, ramREN}, 32'd0);
      end
    end
    check("tmo_strobe_cycles", ren_cnt, 64);
    check("tmo_dwait_lows", dlow, 0);
    dREN = 0;

    // Fetch withdrawn before ACCESS
    do_reset();
    ram_mode = 2;
    iREN = 1; iaddr = 32'h600;
    step(dc, ic);
    check("wd_ramREN_on", {31'b0, ramREN}, 32'd1);
    iREN = 0;
    #1;
    check("wd_ramREN_drop", {31'b0, ramREN}, 32'd0);
    check("wd_iwait", {31'b0, iwait}, 32'd1);
    step(dc, ic);
    check("wd_idle_ramREN", {31'b0, ramREN}, 32'd0);
    check("wd_memerr", {31'b0, memerr}, 32'd0);

    // Asynchronous reset mid-access
    dREN = 1; dWEN = 1; daddr = 32'h700; dstore = 32'hCAFEF00D;
    step(dc, ic);
    step(dc, ic);
    check("rma_ramWEN_on", {31'b0, ramWEN}, 32'd1);
    nRST = 0;
    #1;
    check("rma_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("rma_ramREN", {31'b0, ramREN}, 32'd0);
    check("rma_dwait", {31'b0, dwait}, 32'd1);
    check("rma_ramaddr", ramaddr, 32'd0);
    check("rma_memerr", {31'b0, memerr}, 32'd0);
    dREN = 0; dWEN = 0;
    nRST = 1;
    step(dc, ic);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter directly downstream of the instruction/data cache pair. Accepts the icache fetch request and the dcache read/write request, grants one at a time to the single RAM port, and returns data and wait status to the winning cache. Data requests have priority; a starvation counter guarantees instruction progress. A watchdog flags stalled or errored RAM transactions.

## Interface
- ISTARVE_MAX, 4: consecutive data grants, each with iREN pending, after which the next grant goes to instruction.
- RAM_TIMEOUT, 64: cycles a granted transaction may wait for ACCESS before abort (≥2).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache fetch request.
- iaddr  in  32  fetch address.
- iwait  out  1  low for exactly the completion cycle of a fetch.
- iload  out  32  fetch data; valid when iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins if dREN also high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completion cycle of a data access.
- dload  out  32  read data; valid when dwait low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky error flag (timeout or ERROR); cleared only by reset.

## Operation
- States: IDLE, DATA, INSTR, ERR. Reset → IDLE.
- IDLE: no RAM strobes. Grant on next edge: if (dREN|dWEN) and not (starve==ISTARVE_MAX and iREN) → DATA; else if iREN → INSTR; else stay.
- starve counter (width ≥ clog2(ISTARVE_MAX+1)): on DATA grant with iREN high, increment (saturate at ISTARVE_MAX); on DATA grant with iREN low, clear; on INSTR grant, clear.
- DATA: ramaddr=daddr; dWEN → ramWEN=1, ramstore=dstore; else ramREN=1. INSTR: ramREN=1, ramaddr=iaddr. Cache signals pass through live; caches hold request stable until wait low.
- Completion: in DATA/INSTR when ramstate==ACCESS → matching wait low that cycle, load = ramload; next state IDLE.
- Request withdrawn (granted requester's enable low) before ACCESS → strobes drop same cycle, next state IDLE, wait stays high, no error.
- ramstate==ERROR in DATA/INSTR → next state ERR, memerr set. ERR: strobes low, waits high, one cycle, then IDLE (request re-arbitrated, i.e. retried).
- Timeout counter clears on entry to DATA/INSTR, increments each cycle there; on reaching RAM_TIMEOUT-1 without ACCESS → memerr set, next state IDLE.
- Outputs not in active use: iload/dload = 0, ramaddr = 0, ramstore = 0.

## Timing
- Reset values: state IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, memerr=0, counters 0.
- Request at cycle 0 (IDLE) → RAM strobe at cycle 1 → wait low at first cycle with ACCESS; minimum latency 2 cycles (ACCESS at cycle 1).
- Back-to-back: after completion one IDLE cycle precedes next grant; a pending request re-arbitrates in that cycle.
- Both waits never low in the same cycle; at most one of ramREN/ramWEN high.
- Reset asserted mid-transaction: all outputs to reset values immediately, no completion reported.

## Test plan
- Single read: dREN=1, daddr=0x100, RAM ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF → ramREN high cycles 1–4, dwait low only cycle 4, dload=0xDEADBEEF.
- Write priority: dREN=dWEN=1, dstore=0x12345678 → ramWEN=1, ramREN=0, ramstore=0x12345678; simultaneous iREN waits.
- Starvation: iREN and dREN held high continuously, ACCESS after 1 cycle → grant sequence D,D,D,D,I repeating; iwait low once per 5 transactions.
- Error/timeout: ramstate=ERROR in DATA → memerr=1 next cycle, ERR one cycle, retry grant; separately ramstate held BUSY → abort after 64 cycles, memerr=1, dwait never low.
- Withdrawal: iREN dropped in INSTR before ACCESS → ramREN low same cycle, IDLE next, iwait stays high, memerr=0.
- Reset mid-access: nRST low during DATA → ramREN/ramWEN 0, dwait 1 asynchronously, memerr 0.
